// File: rtl/fp_divide.sv
// FP32 divider: bit-serial restoring mantissa division, truncating,
// subnormals flushed to zero, start/busy/done handshake.
module fp_divide #(
  parameter int          BITS_PER_CYCLE = 1,
  parameter logic [31:0] NAN_PATTERN    = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result,
  output logic        invalid,
  output logic        div_by_zero
);

  localparam int         STEPS = 25 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST  = 5'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE, UNPACK, DIVIDE, NORM
  } state_t;

  state_t             r_state;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_mb;
  logic [24:0]        r_rem;
  logic [24:0]        r_q;
  logic [4:0]         r_cnt;

  logic [7:0]         w_ea;
  logic [7:0]         w_eb;
  logic [22:0]        w_fa;
  logic [22:0]        w_fb;
  logic               w_a_zero;
  logic               w_b_zero;
  logic               w_a_inf;
  logic               w_b_inf;
  logic               w_a_nan;
  logic               w_b_nan;
  logic               w_sign;
  logic signed [9:0]  w_exp0;
  logic signed [9:0]  w_e;
  logic [22:0]        w_frac;
  logic [24:0]        w_rem;
  logic [24:0]        w_q;

  assign w_ea     = r_a[30:23];
  assign w_eb     = r_b[30:23];
  assign w_fa     = r_a[22:0];
  assign w_fb     = r_b[22:0];
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == '0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == '0);
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != '0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != '0);
  assign w_sign   = r_a[31] ^ r_b[31];
  assign w_exp0   = $signed({2'b00, w_ea})
                  - $signed({2'b00, w_eb})
                  + 10'sd126;

  // q[24] set means the ratio is in [1,2): one extra exponent step
  assign w_e    = r_q[24] ? r_exp + 10'sd1 : r_exp;
  assign w_frac = r_q[24] ? r_q[23:1] : r_q[22:0];

  assign busy = (r_state != IDLE);

  always_comb begin
    w_rem = r_rem;
    w_q   = r_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (w_rem >= {1'b0, r_mb}) begin
        w_rem = w_rem - {1'b0, r_mb};
        w_q   = {w_q[23:0], 1'b1};
      end else begin
        w_q   = {w_q[23:0], 1'b0};
      end
      w_rem = {w_rem[23:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mb        <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      done        <= 1'b0;
      Result      <= '0;
      invalid     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_state <= UNPACK;
          end
        end
        UNPACK: begin
          r_sign  <= w_sign;
          r_exp   <= w_exp0;
          r_mb    <= {1'b1, w_fb};
          r_rem   <= {2'b01, w_fa};
          r_q     <= '0;
          r_cnt   <= LAST;
          r_state <= DIVIDE;
          if (w_a_nan || w_b_nan ||
              (w_a_zero && w_b_zero) ||
              (w_a_inf && w_b_inf)) begin
            Result      <= NAN_PATTERN;
            invalid     <= 1'b1;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            r_state     <= IDLE;
          end else if (w_a_inf) begin
            Result      <= {w_sign, 8'hFF, 23'b0};
            invalid     <= 1'b0;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            r_state     <= IDLE;
          end else if (w_b_zero) begin
            Result      <= {w_sign, 8'hFF, 23'b0};
            invalid     <= 1'b0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            r_state     <= IDLE;
          end else if (w_a_zero || w_b_inf) begin
            Result      <= {w_sign, 31'b0};
            invalid     <= 1'b0;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            r_state     <= IDLE;
          end
        end
        DIVIDE: begin
          r_rem <= w_rem;
          r_q   <= w_q;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) r_state <= NORM;
        end
        NORM: begin
          if (w_e >= 10'sd255)
            Result <= {r_sign, 8'hFF, 23'b0};
          else if (w_e <= 10'sd0)
            Result <= {r_sign, 31'b0};
          else
            Result <= {r_sign, w_e[7:0], w_frac};
          invalid     <= 1'b0;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divide.sv
// Bench for fp_divide: vector table through a scoreboard queue,
// plus busy-hold, back-to-back, reset-abort and BPC=5 sequences.
module tb_fp_divide;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        inv;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   scyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, invalid, div_by_zero;
  logic [31:0] Result;

  logic        start5 = 1'b0;
  logic [31:0] A5 = '0;
  logic [31:0] B5 = '0;
  logic        busy5, done5, invalid5, dbz5;
  logic [31:0] Result5;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_done = 0;
  exp_t exp_q[$];

  fp_divide #(.BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .A(A), .B(B), .busy(busy), .done(done),
    .Result(Result), .invalid(invalid),
    .div_by_zero(div_by_zero)
  );

  fp_divide #(.BITS_PER_CYCLE(5)) dut5 (
    .clk(clk), .reset(reset), .start(start5),
    .A(A5), .B(B5), .busy(busy5), .done(done5),
    .Result(Result5), .invalid(invalid5),
    .div_by_zero(dbz5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got 1 want 0");
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("res %h/%h", e.v.a, e.v.b),
            Result, e.v.res);
        chk($sformatf("flags %h/%h", e.v.a, e.v.b),
            {30'b0, invalid, div_by_zero},
            {30'b0, e.v.inv, e.v.dbz});
        chk($sformatf("lat %h/%h", e.v.a, e.v.b),
            32'(cyc - e.scyc), 32'(e.v.lat));
      end
    end
  end

  // caller is at a negedge; returns just after the accepting edge
  task automatic launch(vec_t v);
    exp_t e;
    A = v.a;
    B = v.b;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.v = v;
    e.scyc = cyc;
    exp_q.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) return;
    end
    total++;
    bad++;
    $display("FAIL timeout: got no done want done");
  endtask

  task automatic run5(logic [31:0] a, logic [31:0] b,
                      logic [31:0] want);
    int s;
    int seen;
    @(negedge clk);
    A5 = a;
    B5 = b;
    start5 = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    start5 = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      @(negedge clk);
      if (done5) seen = 1;
    end
    chk("bpc5_done_seen", 32'(seen), 32'd1);
    chk("bpc5_lat", 32'(cyc - s), 32'd7);
    chk("bpc5_res", Result5, want);
    chk("bpc5_flags", {30'b0, invalid5, dbz5}, 32'd0);
  endtask

  vec_t tbl[];
  vec_t v;
  int nd0;

  initial begin
    tbl = new[14];
    tbl[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 27};
    tbl[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 0, 27};
    tbl[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 0, 1, 1};
    tbl[3]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 0, 0, 27};
    tbl[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1, 0, 1};
    tbl[5]  = '{32'h00800000, 32'h40000000, 32'h00000000, 0, 0, 27};
    tbl[6]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 0, 0, 1};
    tbl[7]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1, 0, 1};
    tbl[8]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1, 0, 1};
    tbl[9]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 0, 0, 1};
    tbl[10] = '{32'hC0400000, 32'h7F800000, 32'h80000000, 0, 0, 1};
    tbl[11] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 0, 0, 27};
    tbl[12] = '{32'h40000000, 32'hBF800000, 32'hC0000000, 0, 0, 27};
    tbl[13] = '{32'h41200000, 32'h40800000, 32'h40200000, 0, 0, 27};

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_flags", {30'b0, invalid, div_by_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      launch(tbl[i]);
      if (i == 0) chk("busy_after_accept", {31'b0, busy}, 32'd1);
      wait_done();
      @(negedge clk);
      chk("done_one_cycle", {31'b0, done}, 32'd0);
    end

    run5(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
    run5(32'h40C00000, 32'h40000000, 32'h40400000);

    // start held high with A/B changing while busy
    @(negedge clk);
    nd0 = n_done;
    v = '{32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 27};
    launch(v);
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) break;
      A = $urandom;
      B = $urandom;
    end
    start = 1'b0;
    repeat (35) @(negedge clk);
    chk("hold_single_done", 32'(n_done - nd0), 32'd1);
    chk("hold_idle", {31'b0, busy}, 32'd0);

    // back-to-back start on the done cycle
    v = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 0, 27};
    launch(v);
    wait_done();
    v = '{32'h41200000, 32'h40800000, 32'h40200000, 0, 0, 27};
    launch(v);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    wait_done();
    @(negedge clk);

    // asynchronous reset mid-division
    v = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 0, 0, 27};
    launch(v);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_result", Result, 32'd0);
    chk("arst_flags", {30'b0, invalid, div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    v = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 0, 27};
    launch(v);
    wait_done();
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
